// File: rtl/instr_prefetch_unit.sv
// Pipelined instruction prefetcher: PC generation, up to MAX_OUTSTANDING memory reads
// in flight, FIFO_DEPTH-entry prefetch queue. Optional macro IF_MISALIGN_CHECK_EN.
module instr_prefetch_unit #(
    parameter int unsigned      XLEN            = 32,
    parameter logic [XLEN-1:0]  RESET_PC        = '0,
    parameter int unsigned      FIFO_DEPTH      = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            was_branch,
    input  logic [XLEN-1:0] branch_result,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    // Handshakes: a request transfers on imem_req & imem_gnt and, once raised, holds
    // req/addr until granted; a response transfers on imem_rvalid (no backpressure);
    // the queue head transfers to decode on instr_valid & instr_ready.

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  pend_addr;
    logic             pend_q;
    logic             stale_q;
    logic             fault_q;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] discard_cnt;
    logic [OUT_W-1:0] out_next;

    logic [XLEN-1:0]  q_pc    [FIFO_DEPTH];
    logic [31:0]      q_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] q_count;

    logic [31:0]      credit_used;
    logic             can_issue;
    logic             req_fire;
    logic             rsp_take;
    logic             rsp_push;
    logic             pop;
    logic [XLEN-1:0]  target;

`ifdef IF_MISALIGN_CHECK_EN
    assign target = {branch_result[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (was_branch) begin
            fault_q <= |branch_result[1:0];
        end
    end
`else
    logic unused_lo_bits;
    assign unused_lo_bits = ^branch_result[1:0];
    assign target         = {branch_result[XLEN-1:2], 2'b00};
    assign fault_q        = 1'b0;
`endif

    assign fetch_fault = fault_q;

    always_comb begin
        credit_used = 32'(outstanding) + 32'(q_count);
        // rst gating keeps imem_req low for the whole time reset is held
        can_issue   = rst && !pend_q && !was_branch && !fault_q
                      && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                      && (credit_used < 32'(FIFO_DEPTH));
        imem_req    = pend_q | can_issue;
        imem_addr   = pend_q ? pend_addr : fetch_pc;
        req_fire    = imem_req & imem_gnt;
        rsp_take    = imem_rvalid & (outstanding != '0);
        rsp_push    = rsp_take & (discard_cnt == '0) & ~was_branch;
        pop         = instr_valid & instr_ready;
        out_next    = outstanding + OUT_W'(req_fire) - OUT_W'(rsp_take);
    end

    // A request still waiting for grant at a redirect is stale: when it is finally
    // granted it must not advance fetch_pc and its response joins the discard count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            pend_addr   <= RESET_PC;
            pend_q      <= 1'b0;
            stale_q     <= 1'b0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            pend_q      <= imem_req & ~imem_gnt;
            pend_addr   <= imem_addr;
            outstanding <= out_next;
            if (was_branch) begin
                fetch_pc    <= target;
                resp_pc     <= target;
                discard_cnt <= out_next;
                stale_q     <= imem_req & ~imem_gnt;
            end else begin
                if (req_fire && !stale_q) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                discard_cnt <= discard_cnt
                               - OUT_W'(rsp_take && (discard_cnt != '0))
                               + OUT_W'(req_fire && stale_q);
                if (req_fire) begin
                    stale_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else if (was_branch) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (rsp_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            q_count <= q_count + CNT_W'(rsp_push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; outputs are masked by instr_valid.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_comb begin
        instr_valid = (q_count != '0);
        instr_out   = instr_valid ? q_instr[rd_ptr] : '0;
        instr_pc    = instr_valid ? q_pc[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with an in-order memory model (data = address).
module tb_instr_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        was_branch = 1'b0;
    logic [31:0] branch_result = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int vectors = 0;
    int miscompares = 0;

    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    logic [31:0] rq_addr[$];
    int unsigned rq_due[$];
    logic [31:0] req_log[$];

    instr_prefetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .was_branch   (was_branch),
        .branch_result(branch_result),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .fetch_fault  (fetch_fault)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // memory model: handshake sampled at the edge, response driven #1 after it
    always @(posedge clk) begin
        if (!rst) begin
            rq_addr.delete();
            rq_due.delete();
            req_log.delete();
        end else if (imem_req && imem_gnt) begin
            rq_addr.push_back(imem_addr);
            rq_due.push_back(cyc + mem_lat);
            req_log.push_back(imem_addr);
        end
        cyc = cyc + 1;
        #1;
        if (rst && rq_due.size() > 0 && rq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rq_addr.pop_front();
            void'(rq_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    // driver tasks
    task automatic hold_reset(input int unsigned lat, input logic g, input logic r);
        @(negedge clk);
        rst         = 1'b0;
        was_branch  = 1'b0;
        mem_lat     = lat;
        imem_gnt    = g;
        instr_ready = r;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(negedge clk);
        was_branch    = 1'b1;
        branch_result = tgt;
        #1;
        @(negedge clk);
        was_branch = 1'b0;
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        hold_reset(1, 1'b1, 1'b1);
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            instr_out !== 32'h0 || instr_pc !== 32'h0 || fetch_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b out=%h pc=%h fault=%b want 0,0,0,0,0,0",
                     imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_fault);
        end
        release_reset();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_cycle0: req=%b addr=%h valid=%b want 1,0,0", imem_req, imem_addr, instr_valid);
        end
        step();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_cycle1: req=%b addr=%h valid=%b want 1,4,0", imem_req, imem_addr, instr_valid);
        end
        for (int k = 2; k < 10; k++) begin
            step();
            exp_pc = 32'(4 * (k - 2));
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== exp_pc) begin
                miscompares++;
                $display("FAIL stream_cycle%0d: valid=%b pc=%h instr=%h want 1,%h,%h",
                         k, instr_valid, instr_pc, instr_out, exp_pc, exp_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        hold_reset(1, 1'b1, 1'b0);
        release_reset();
        repeat (9) step();
        vectors++;
        if (req_log.size() != 4 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_grant_count: grants=%0d req=%b want 4,0", req_log.size(), imem_req);
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            exp_pc = 32'(4 * i);
            vectors++;
            if (req_log[i] !== exp_pc) begin
                miscompares++;
                $display("FAIL bp_req_addr%0d: got %h want %h", i, req_log[i], exp_pc);
            end
        end
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            exp_pc = 32'(4 * i);
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== exp_pc) begin
                miscompares++;
                $display("FAIL bp_drain%0d: valid=%b pc=%h instr=%h want 1,%h,%h",
                         i, instr_valid, instr_pc, instr_out, exp_pc, exp_pc);
            end
        end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] exp_a;
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        step();
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            imem_gnt = (c == 5);
            #1;
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                miscompares++;
                $display("FAIL stall_hold_c%0d: req=%b addr=%h want 1,8", c, imem_req, imem_addr);
            end
        end
        repeat (4) step();
        vectors++;
        if (req_log.size() < 4) begin
            miscompares++;
            $display("FAIL stall_grants: got %0d want >=4", req_log.size());
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            exp_a = 32'(4 * i);
            vectors++;
            if (req_log[i] !== exp_a) begin
                miscompares++;
                $display("FAIL stall_req%0d: got %h want %h", i, req_log[i], exp_a);
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        bit ok;
        hold_reset(3, 1'b1, 1'b0);
        release_reset();
        repeat (6) step();
        @(negedge clk);
        was_branch    = 1'b1;
        branch_result = 32'h100;
        instr_ready   = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL redir_cycle: req=%b valid=%b pc=%h want 0,1,0", imem_req, instr_valid, instr_pc);
        end
        @(negedge clk);
        was_branch = 1'b0;
        #1;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flush: valid=%b want 0", instr_valid);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h100 || instr_out !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_first: seen=%b pc=%h instr=%h want 1,100,100", ok, instr_pc, instr_out);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h104) begin
            miscompares++;
            $display("FAIL redir_second: seen=%b pc=%h want 1,104", ok, instr_pc);
        end
    endtask

    task automatic test_redirect_pending();
        bit ok;
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        repeat (3) step();
        @(negedge clk);
        imem_gnt = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL pend_raise: req=%b addr=%h want 1,10", imem_req, imem_addr);
        end
        @(negedge clk);
        was_branch    = 1'b1;
        branch_result = 32'h200;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL pend_redir: req=%b addr=%h want 1,10", imem_req, imem_addr);
        end
        for (int c = 6; c < 8; c++) begin
            @(negedge clk);
            was_branch = 1'b0;
            imem_gnt   = (c == 7);
            #1;
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL pend_hold_c%0d: req=%b addr=%h valid=%b want 1,10,0",
                         c, imem_req, imem_addr, instr_valid);
            end
        end
        step();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL pend_next_req: req=%b addr=%h want 1,200", imem_req, imem_addr);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h200 || instr_out !== 32'h200) begin
            miscompares++;
            $display("FAIL pend_first: seen=%b pc=%h instr=%h want 1,200,200", ok, instr_pc, instr_out);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        hold_reset(2, 1'b1, 1'b1);
        release_reset();
        repeat (4) step();
        @(negedge clk);
        was_branch    = 1'b1;
        branch_result = 32'h300;
        #1;
        redirect(32'h400);
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h400 || instr_out !== 32'h400) begin
            miscompares++;
            $display("FAIL b2b_first: seen=%b pc=%h instr=%h want 1,400,400", ok, instr_pc, instr_out);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h404) begin
            miscompares++;
            $display("FAIL b2b_second: seen=%b pc=%h want 1,404", ok, instr_pc);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_q[$];
        logic [31:0] exp_pc;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        repeat (3) step();
        redirect(32'hFFFF_FFF8);
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            wait_valid(ok);
            vectors++;
            if (!ok || instr_pc !== exp_pc || instr_out !== exp_pc) begin
                miscompares++;
                $display("FAIL wrap_pc: seen=%b pc=%h instr=%h want 1,%h,%h",
                         ok, instr_pc, instr_out, exp_pc, exp_pc);
            end
        end
    endtask

`ifdef IF_MISALIGN_CHECK_EN
    task automatic test_misalign();
        bit ok;
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        repeat (3) step();
        redirect(32'h102);
        vectors++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_set: fault=%b valid=%b want 1,0", fetch_fault, instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1) begin
                miscompares++;
                $display("FAIL fault_quiet%0d: req=%b valid=%b fault=%b want 0,0,1",
                         i, imem_req, instr_valid, fetch_fault);
            end
        end
        redirect(32'h200);
        vectors++;
        if (fetch_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_clear: fault=%b want 0", fetch_fault);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h200) begin
            miscompares++;
            $display("FAIL fault_resume: seen=%b pc=%h want 1,200", ok, instr_pc);
        end
    endtask
`else
    task automatic test_misalign();
        bit ok;
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        repeat (3) step();
        redirect(32'h102);
        wait_valid(ok);
        vectors++;
        if (!ok || instr_pc !== 32'h100 || instr_out !== 32'h100 || fetch_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_forced: seen=%b pc=%h instr=%h fault=%b want 1,100,100,0",
                     ok, instr_pc, instr_out, fetch_fault);
        end
    endtask
`endif

    task automatic test_mid_reset();
        hold_reset(1, 1'b1, 1'b1);
        release_reset();
        repeat (4) step();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b req=%b addr=%h pc=%h want 0,0,0,0",
                     instr_valid, imem_req, imem_addr, instr_pc);
        end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_outstanding();
        test_redirect_pending();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
